// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared types for the single-outstanding APB4 initiator
package apb_master_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef logic [APB_ADDR_W-1:0]   apb_addr_t;
   typedef logic [APB_DATA_W-1:0]   data_t;
   typedef logic [APB_DATA_W/8-1:0] strb_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_master_state_e;

   typedef struct packed {
      logic      write;
      apb_addr_t addr;
      data_t     data;
      strb_t     strb;
   } apb_req_t;

endpackage

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready command to APB4 SETUP/ACCESS transfer with timeout
module apb_master
   import apb_master_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 256
) (
   input  logic                pclk_i,
   input  logic                preset_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_write_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   input  logic [DATA_W/8-1:0] req_strb_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_rdata_o,
   output logic                rsp_err_o,
   output logic                rsp_timeout_o,
   output logic                psel_o,
   output logic                penable_o,
   output logic                pwrite_o,
   output logic [ADDR_W-1:0]   paddr_o,
   output logic [DATA_W-1:0]   pwdata_o,
   output logic [DATA_W/8-1:0] pstrb_o,
   input  logic                pready_i,
   input  logic                pslverr_i,
   input  logic [DATA_W-1:0]   prdata_i
);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_SETUP  = ST_SETUP;
   localparam logic [1:0] S_ACCESS = ST_ACCESS;
   localparam logic [1:0] S_RESP   = ST_RESP;

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [1:0]       state_q;
   apb_req_t         req_q;
   logic [CNT_W-1:0] tmo_q;
   data_t            rdata_q;
   logic             err_q;
   logic             tout_q;
   logic             sel;
   logic             abort;

   assign sel   = (state_q == S_SETUP) || (state_q == S_ACCESS);
   // pready in the final allowed cycle still completes the transfer normally
   assign abort = (TIMEOUT != 0) && !pready_i && (tmo_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge pclk_i) begin
      if (!preset_ni) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         tmo_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  // read commands latch zero data/strobes so the bus shows 0 for them
                  req_q.write <= req_write_i;
                  req_q.addr  <= req_addr_i;
                  req_q.data  <= req_write_i ? req_wdata_i : '0;
                  req_q.strb  <= req_write_i ? req_strb_i : '0;
                  state_q     <= S_SETUP;
               end
            end
            S_SETUP: begin
               tmo_q   <= '0;
               state_q <= S_ACCESS;
            end
            S_ACCESS: begin
               if (pready_i) begin
                  rdata_q <= req_q.write ? '0 : prdata_i;
                  err_q   <= pslverr_i;
                  tout_q  <= 1'b0;
                  state_q <= S_RESP;
               end else if (abort) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  tout_q  <= 1'b1;
                  state_q <= S_RESP;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready_i) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready_o   = (state_q == S_IDLE) && preset_ni;
   assign rsp_valid_o   = (state_q == S_RESP);
   assign rsp_rdata_o   = rsp_valid_o ? rdata_q : '0;
   assign rsp_err_o     = rsp_valid_o && err_q;
   assign rsp_timeout_o = rsp_valid_o && tout_q;

   assign psel_o    = sel;
   assign penable_o = (state_q == S_ACCESS);
   assign pwrite_o  = sel && req_q.write;
   assign paddr_o   = sel ? req_q.addr : '0;
   assign pwdata_o  = sel ? req_q.data : '0;
   assign pstrb_o   = sel ? req_q.strb : '0;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master with a memory-backed APB slave
module tb_apb_master;

   logic        clk = 1'b0;
   logic        preset_n;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_strb;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic        pready, pslverr;
   logic [31:0] prdata;

   int tests = 0;
   int fails = 0;

   int ws_cfg = 0;
   bit err_cfg = 0;
   bit early_err_cfg = 0;
   bit hang_cfg = 0;
   int acc_cnt = 0;
   logic [31:0] slave_mem [16];
   logic [31:0] ref_mem [16];

   always #5 clk = ~clk;

   apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .pclk_i(clk), .preset_ni(preset_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
      .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
      .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb),
      .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata)
   );

   // APB slave: completes after ws_cfg wait states, or never when hang_cfg is set
   always @(negedge clk) begin
      if (psel && penable) begin
         if (!hang_cfg && acc_cnt == ws_cfg) begin
            pready  = 1'b1;
            pslverr = err_cfg;
            prdata  = pwrite ? $urandom : slave_mem[paddr[5:2]];
            if (pwrite && !err_cfg)
               for (int b = 0; b < 4; b++)
                  if (pstrb[b]) slave_mem[paddr[5:2]][8*b +: 8] = pwdata[8*b +: 8];
         end else begin
            pready  = 1'b0;
            pslverr = early_err_cfg;
            prdata  = $urandom;
         end
         acc_cnt++;
      end else begin
         acc_cnt = 0;
         pready  = 1'b0;
         pslverr = early_err_cfg;
         prdata  = $urandom;
      end
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // lat counts cycles from the accept edge to the first cycle rsp_valid is seen
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input int hold, input bit hold_valid,
                          output logic [31:0] rd, output bit err, output bit tmo,
                          output int lat, output int acc_n, output bit apb_bad,
                          output bit hold_bad);
      int n;
      req_write = wr; req_addr = addr; req_wdata = wd; req_strb = st; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; acc_n = 0; apb_bad = 0; hold_bad = 0;
      if (n >= 50) lat = -1000;
      if (penable) apb_bad = 1;
      while (!rsp_valid && lat < 60) begin
         if (!psel || paddr !== addr || pwrite !== wr || pstrb !== (wr ? st : 4'h0) ||
             pwdata !== (wr ? wd : 32'h0)) apb_bad = 1;
         if (penable) acc_n++;
         @(negedge clk);
         lat++;
      end
      if (psel || penable || paddr !== 32'h0 || pstrb !== 4'h0) apb_bad = 1;
      rd = rsp_rdata; err = rsp_err; tmo = rsp_timeout;
      for (int h = 0; h < hold; h++) begin
         req_valid = hold_valid;
         @(negedge clk);
         if (!rsp_valid || rsp_rdata !== rd || rsp_err !== err || rsp_timeout !== tmo ||
             req_ready || psel) hold_bad = 1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      preset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
      repeat (3) @(negedge clk);
      tests++;
      if ({req_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite} !== 7'b0) begin
         fails++;
         $display("FAIL reset_ctrl got %b want 0000000",
                  {req_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite});
      end
      tests++;
      if (paddr !== 0 || pwdata !== 0 || pstrb !== 0 || rsp_rdata !== 0) begin
         fails++;
         $display("FAIL reset_data got %h %h %h %h want all 0", paddr, pwdata, pstrb, rsp_rdata);
      end
      preset_n = 1'b1;
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1 || psel !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle got ready=%b psel=%b want 1 0", req_ready, psel);
      end
   endtask

   task automatic test_write_zero_wait();
      logic [31:0] rd; bit e, t, ab, hb; int lat, an;
      ws_cfg = 0;
      run_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, e, t, lat, an, ab, hb);
      ref_mem[4] = merge(ref_mem[4], 32'hDEADBEEF, 4'hF);
      tests++;
      if (lat !== 3 || an !== 1) begin
         fails++; $display("FAIL wr_latency got lat=%0d acc=%0d want 3 1", lat, an);
      end
      tests++;
      if (e !== 0 || t !== 0 || rd !== 32'h0 || ab) begin
         fails++; $display("FAIL wr_rsp got err=%b tmo=%b rd=%h bad=%b want 0 0 0 0", e, t, rd, ab);
      end
   endtask

   task automatic test_read_wait_states();
      logic [31:0] rd; bit e, t, ab, hb; int lat, an;
      ws_cfg = 0;
      run_txn(1, 32'h20, 32'h12345678, 4'hF, 0, 0, rd, e, t, lat, an, ab, hb);
      ref_mem[8] = merge(ref_mem[8], 32'h12345678, 4'hF);
      ws_cfg = 3;
      run_txn(0, 32'h20, 32'h0, 4'h0, 0, 0, rd, e, t, lat, an, ab, hb);
      tests++;
      if (an !== 4 || lat !== 6 || ab) begin
         fails++; $display("FAIL rd_wait got acc=%0d lat=%0d bad=%b want 4 6 0", an, lat, ab);
      end
      tests++;
      if (rd !== ref_mem[8] || e !== 0 || t !== 0) begin
         fails++; $display("FAIL rd_data got %h err=%b want %h 0", rd, e, ref_mem[8]);
      end
   endtask

   task automatic test_slverr();
      logic [31:0] rd; bit e, t, ab, hb; int lat, an;
      ws_cfg = 2; err_cfg = 1; early_err_cfg = 0;
      run_txn(0, 32'h04, 32'h0, 4'h0, 0, 0, rd, e, t, lat, an, ab, hb);
      tests++;
      if (e !== 1 || t !== 0 || rd !== ref_mem[1]) begin
         fails++; $display("FAIL slverr got err=%b tmo=%b rd=%h want 1 0 %h", e, t, rd, ref_mem[1]);
      end
      err_cfg = 0; early_err_cfg = 1;
      run_txn(0, 32'h04, 32'h0, 4'h0, 0, 0, rd, e, t, lat, an, ab, hb);
      early_err_cfg = 0;
      tests++;
      if (e !== 0 || t !== 0 || lat !== 5) begin
         fails++; $display("FAIL early_err got err=%b tmo=%b lat=%0d want 0 0 5", e, t, lat);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] rd; bit e, t, ab, hb; int lat, an;
      hang_cfg = 1; ws_cfg = 0;
      run_txn(0, 32'h30, 32'h0, 4'h0, 0, 0, rd, e, t, lat, an, ab, hb);
      hang_cfg = 0;
      tests++;
      if (an !== 8 || lat !== 10 || ab) begin
         fails++; $display("FAIL timeout_len got acc=%0d lat=%0d bad=%b want 8 10 0", an, lat, ab);
      end
      tests++;
      if (e !== 1 || t !== 1 || rd !== 32'h0) begin
         fails++; $display("FAIL timeout_rsp got err=%b tmo=%b rd=%h want 1 1 0", e, t, rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; bit e, t, ab, hb; int lat, an;
      ws_cfg = 0;
      run_txn(0, 32'h10, 32'h0, 4'h0, 5, 1, rd, e, t, lat, an, ab, hb);
      tests++;
      if (hb || rd !== ref_mem[4]) begin
         fails++; $display("FAIL hold_stable got hold_bad=%b rd=%h want 0 %h", hb, rd, ref_mem[4]);
      end
      tests++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         fails++; $display("FAIL after_hs got ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
      end
      run_txn(0, 32'h10, 32'h0, 4'h0, 0, 0, rd, e, t, lat, an, ab, hb);
      tests++;
      if (lat !== 3 || rd !== ref_mem[4] || ab) begin
         fails++; $display("FAIL b2b_second got lat=%0d rd=%h want 3 %h", lat, rd, ref_mem[4]);
      end
   endtask

   task automatic test_reset_mid_access();
      logic [31:0] rd; bit e, t, ab, hb, seen; int lat, an, n;
      hang_cfg = 1;
      req_write = 1'b0; req_addr = 32'h18; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0;
      while (!penable && n < 40) begin @(negedge clk); n++; end
      @(negedge clk);
      preset_n = 1'b0;
      @(negedge clk);
      tests++;
      if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || n >= 40) begin
         fails++; $display("FAIL mid_reset got psel=%b penable=%b rsp_valid=%b want 0 0 0",
                           psel, penable, rsp_valid);
      end
      preset_n = 1'b1; hang_cfg = 0;
      seen = 0;
      repeat (4) begin @(negedge clk); if (rsp_valid || psel) seen = 1; end
      tests++;
      if (seen) begin
         fails++; $display("FAIL post_reset_quiet got activity=1 want 0");
      end
      ws_cfg = 1;
      run_txn(1, 32'h18, 32'hA5A55A5A, 4'h5, 0, 0, rd, e, t, lat, an, ab, hb);
      ref_mem[6] = merge(ref_mem[6], 32'hA5A55A5A, 4'h5);
      tests++;
      if (lat !== 4 || e !== 0 || t !== 0 || ab) begin
         fails++; $display("FAIL post_reset_txn got lat=%0d err=%b tmo=%b want 4 0 0", lat, e, t);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, wd, exp_rd; logic [3:0] st; bit e, t, ab, hb, wr, hang, ee; int lat, an, idx;
      int exp_acc;
      for (int i = 0; i < 30; i++) begin
         wr = $urandom_range(0, 1) == 1;
         idx = $urandom_range(0, 15);
         wd = $urandom;
         st = 4'($urandom);
         hang = $urandom_range(0, 5) == 0;
         ee = $urandom_range(0, 4) == 0;
         ws_cfg = $urandom_range(0, 3);
         err_cfg = ee; hang_cfg = hang; early_err_cfg = $urandom_range(0, 1) == 1;
         run_txn(wr, 32'(idx * 4), wd, st, $urandom_range(0, 2), 0, rd, e, t, lat, an, ab, hb);
         exp_acc = hang ? 8 : ws_cfg + 1;
         exp_rd  = (hang || wr) ? 32'h0 : ref_mem[idx];
         if (wr && !hang && !ee) ref_mem[idx] = merge(ref_mem[idx], wd, st);
         tests++;
         if (lat !== exp_acc + 2 || an !== exp_acc || ab || hb) begin
            fails++; $display("FAIL rnd%0d_timing got lat=%0d acc=%0d bad=%b%b want %0d %0d 00",
                              i, lat, an, ab, hb, exp_acc + 2, exp_acc);
         end
         tests++;
         if (rd !== exp_rd || e !== (hang | ee) || t !== hang) begin
            fails++; $display("FAIL rnd%0d_rsp got rd=%h err=%b tmo=%b want %h %b %b",
                              i, rd, e, t, exp_rd, hang | ee, hang);
         end
      end
      hang_cfg = 0; err_cfg = 0; early_err_cfg = 0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         slave_mem[i] = 32'h0101_0101 * i;
         ref_mem[i]   = 32'h0101_0101 * i;
      end
      test_reset();
      test_write_zero_wait();
      test_read_wait_states();
      test_slverr();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
